// File: rtl/meduram_nwmr_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | meduram_nwmr_if : write/read port bundle for meduram_nwmr         |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface meduram_nwmr_if #(
  parameter int NB_WR      = 4,
  parameter int NB_RD      = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
);
  logic                        ready;
  logic [NB_WR-1:0]            wren;
  logic [NB_WR*ADDR_WIDTH-1:0] wraddr;
  logic [NB_WR*DATA_WIDTH-1:0] wrdata;
  logic [NB_RD-1:0]            rden;
  logic [NB_RD*ADDR_WIDTH-1:0] rdaddr;
  logic [NB_RD*DATA_WIDTH-1:0] rddata;
  logic [NB_RD-1:0]            rdvalid;
  logic [NB_WR-1:0]            collision;

  modport master (
    input  ready, rddata, rdvalid, collision,
    output wren, wraddr, wrdata, rden, rdaddr
  );

  modport slave (
    output ready, rddata, rdvalid, collision,
    input  wren, wraddr, wrdata, rden, rdaddr
  );
endinterface
`default_nettype wire

// File: rtl/meduram_nwmr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | meduram_nwmr : NB_WR-write / NB_RD-read RAM, LVT-banked, cleared  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module meduram_nwmr #(
  parameter int NB_WR         = 4,
  parameter int NB_RD         = 4,
  parameter int ADDR_WIDTH    = 9,
  parameter int RAM_DEPTH     = 512,
  parameter int DATA_WIDTH    = 64,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input wire logic      aclk,
  input wire logic      arstn,
  meduram_nwmr_if.slave bus
);
  localparam int LVT_W = (NB_WR > 1) ? $clog2(NB_WR) : 1;
  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    ready_r;
  logic [NB_WR-1:0]        collision_r;

  logic [ADDR_WIDTH-1:0]   wa [NB_WR];
  logic [DATA_WIDTH-1:0]   wd [NB_WR];
  logic [NB_WR-1:0]        wr_req, wr_win, wr_lose;

  logic [DATA_WIDTH-1:0]   mem [NB_WR][NB_RD][RAM_DEPTH];
  logic [LVT_W-1:0]        lvt [RAM_DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state   <= RST_STATE;
      cnt     <= '0;
      ready_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_r <= (state_nxt == ST_RUN);
    end
  end

  for (genvar i = 0; i < NB_WR; i++) begin : g_wr_unpack
    assign wa[i]     = bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[i]     = bus.wrdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wr_req[i] = ready_r && bus.wren[i] && ({1'b0, wa[i]} < DEPTH_X);
  end

  // Lowest-index requester at an address wins; out-of-range writes never request.
  always_comb begin
    wr_win  = wr_req;
    wr_lose = '0;
    for (int i = 1; i < NB_WR; i++) begin
      for (int j = 0; j < i; j++) begin
        if (wr_req[i] && wr_req[j] && (wa[i] == wa[j])) begin
          wr_win[i]  = 1'b0;
          wr_lose[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (state == ST_INIT) begin
      for (int i = 0; i < NB_WR; i++)
        for (int k = 0; k < NB_RD; k++)
          mem[i][k][cnt[IDX_W-1:0]] <= '0;
      lvt[cnt[IDX_W-1:0]] <= '0;
    end else begin
      for (int i = 0; i < NB_WR; i++) begin
        if (wr_win[i]) begin
          for (int k = 0; k < NB_RD; k++)
            mem[i][k][wa[i][IDX_W-1:0]] <= wd[i];
          lvt[wa[i][IDX_W-1:0]] <= LVT_W'(i);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) collision_r <= '0;
    else        collision_r <= wr_lose;
  end

  assign bus.ready     = ready_r;
  assign bus.collision = collision_r;

  for (genvar k = 0; k < NB_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] val;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    assign ra       = bus.rdaddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range = ({1'b0, ra} < DEPTH_X);

    // Each read port owns its replica, so lookups never contend.
    always_comb begin
      val = '0;
      if (in_range) begin
        val = mem[lvt[ra[IDX_W-1:0]]][k][ra[IDX_W-1:0]];
        if (RDW_MODE != 0) begin
          for (int i = 0; i < NB_WR; i++)
            if (wr_win[i] && (wa[i] == ra)) val = wd[i];
        end
      end
    end

    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= ready_r && bus.rden[k];
        if (ready_r && bus.rden[k]) data_q <= val;
      end
    end

    assign bus.rddata[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign bus.rdvalid[k]                         = valid_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_meduram_nwmr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_meduram_nwmr : randomized + directed bench with array model    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_meduram_nwmr;
  localparam int NW = 4, NR = 4, AW = 9, DW = 64, DEPTH_A = 512;

  logic clk = 1'b0;
  logic rstn_a, rstn_b;
  always #5 clk = ~clk;

  meduram_nwmr_if #(.NB_WR(NW), .NB_RD(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  meduram_nwmr_if #(.NB_WR(NW), .NB_RD(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  meduram_nwmr #(
    .NB_WR(NW), .NB_RD(NR), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH_A),
    .DATA_WIDTH(DW), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) dut_a (.aclk(clk), .arstn(rstn_a), .bus(bus_a));

  meduram_nwmr #(
    .NB_WR(NW), .NB_RD(NR), .ADDR_WIDTH(AW), .RAM_DEPTH(300),
    .DATA_WIDTH(DW), .RDW_MODE(1), .INIT_ON_RESET(0)
  ) dut_b (.aclk(clk), .arstn(rstn_b), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model for dut_a: plain word array, last read result per port.
  logic [DW-1:0] m_mem [DEPTH_A];
  logic [DW-1:0] m_rd  [NR];
  int            since_rel;

  task automatic clear_a();
    bus_a.wren = '0; bus_a.wraddr = '0; bus_a.wrdata = '0;
    bus_a.rden = '0; bus_a.rdaddr = '0;
  endtask

  task automatic clear_b();
    bus_b.wren = '0; bus_b.wraddr = '0; bus_b.wrdata = '0;
    bus_b.rden = '0; bus_b.rdaddr = '0;
  endtask

  task automatic wr_a(input int p, input int addr, input logic [DW-1:0] d);
    bus_a.wren[p] = 1'b1;
    bus_a.wraddr[p*AW +: AW] = AW'(addr);
    bus_a.wrdata[p*DW +: DW] = d;
  endtask

  task automatic rd_a(input int p, input int addr);
    bus_a.rden[p] = 1'b1;
    bus_a.rdaddr[p*AW +: AW] = AW'(addr);
  endtask

  task automatic wr_b(input int p, input int addr, input logic [DW-1:0] d);
    bus_b.wren[p] = 1'b1;
    bus_b.wraddr[p*AW +: AW] = AW'(addr);
    bus_b.wrdata[p*DW +: DW] = d;
  endtask

  task automatic rd_b(input int p, input int addr);
    bus_b.rden[p] = 1'b1;
    bus_b.rdaddr[p*AW +: AW] = AW'(addr);
  endtask

  task automatic rand_a();
    for (int i = 0; i < NW; i++) begin
      bus_a.wren[i] = 1'($urandom_range(0, 1));
      bus_a.wraddr[i*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      bus_a.wrdata[i*DW +: DW] = {$urandom, $urandom};
    end
    for (int k = 0; k < NR; k++) begin
      bus_a.rden[k] = 1'($urandom_range(0, 1));
      bus_a.rdaddr[k*AW +: AW] = AW'($urandom_range(0, 15));
    end
  endtask

  // One clock of dut_a: model the edge from the spec rules, then compare.
  task automatic tick_a();
    logic [NR-1:0] exp_v;
    logic [NW-1:0] exp_col;
    logic [AW-1:0] a;
    logic [AW-1:0] used [$];
    bit            rdy, dup;
    exp_v   = '0;
    exp_col = '0;
    rdy     = (since_rel >= DEPTH_A);
    for (int k = 0; k < NR; k++) begin
      if (rdy && bus_a.rden[k]) begin
        a        = bus_a.rdaddr[k*AW +: AW];
        m_rd[k]  = m_mem[a];
        exp_v[k] = 1'b1;
      end
    end
    for (int i = 0; i < NW; i++) begin
      if (rdy && bus_a.wren[i]) begin
        a   = bus_a.wraddr[i*AW +: AW];
        dup = 1'b0;
        foreach (used[u]) if (used[u] == a) dup = 1'b1;
        if (dup) exp_col[i] = 1'b1;
        else begin
          used.push_back(a);
          m_mem[a] = bus_a.wrdata[i*DW +: DW];
        end
      end
    end
    @(posedge clk); #1;
    since_rel++;
    check("ready", 64'(bus_a.ready), 64'(since_rel >= DEPTH_A));
    check("rdvalid", 64'(bus_a.rdvalid), 64'(exp_v));
    check("collision", 64'(bus_a.collision), 64'(exp_col));
    for (int k = 0; k < NR; k++)
      check($sformatf("rddata%0d", k), bus_a.rddata[k*DW +: DW], m_rd[k]);
  endtask

  task automatic reset_a();
    clear_a();
    @(negedge clk);
    rstn_a = 1'b0;
    #1;
    check("rst_ready", 64'(bus_a.ready), 64'd0);
    check("rst_rdvalid", 64'(bus_a.rdvalid), 64'd0);
    check("rst_collision", 64'(bus_a.collision), 64'd0);
    check("rst_rddata0", bus_a.rddata[0 +: DW], 64'd0);
    @(posedge clk); #1;
    rstn_a    = 1'b1;
    since_rel = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_rd[k])  m_rd[k]  = '0;
  endtask

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    since_rel = 0;
    clear_a();
    clear_b();
    repeat (3) @(posedge clk);

    // Sweep interrupted at cycle 200, then a full sweep; traffic during INIT is ignored.
    reset_a();
    repeat (200) begin rand_a(); tick_a(); end
    reset_a();
    repeat (DEPTH_A) begin rand_a(); tick_a(); end
    clear_a();

    for (int c = 0; c < DEPTH_A / NR; c++) begin
      clear_a();
      for (int k = 0; k < NR; k++) rd_a(k, c * NR + k);
      tick_a();
    end

    // Later write from another port replaces the live value.
    clear_a(); wr_a(0, 5, 64'hAAAA); tick_a();
    clear_a(); wr_a(3, 5, 64'h5555); tick_a();
    clear_a(); for (int k = 0; k < NR; k++) rd_a(k, 5); tick_a();
    for (int k = 0; k < NR; k++) check("t2_rd5", bus_a.rddata[k*DW +: DW], 64'h5555);
    clear_a(); tick_a();

    // Three-way collision.
    clear_a(); wr_a(1, 100, 64'h11); wr_a(2, 100, 64'h22); wr_a(3, 100, 64'h33); tick_a();
    check("t3_collision", 64'(bus_a.collision), 64'h0C);
    clear_a(); rd_a(0, 100); tick_a();
    check("t3_rd100", bus_a.rddata[0 +: DW], 64'h11);

    // Read-during-write returns old data.
    clear_a(); wr_a(0, 7, 64'h1); tick_a();
    clear_a(); wr_a(0, 7, 64'h2); rd_a(1, 7); tick_a();
    check("t4_rdw_old", bus_a.rddata[1*DW +: DW], 64'h1);
    clear_a(); rd_a(1, 7); tick_a();

    repeat (2000) begin rand_a(); tick_a(); end
    clear_a();
    tick_a();

    // dut_b: no clear, 300 words, new-data bypass.
    @(posedge clk); #1;
    rstn_b = 1'b1;
    check("b_ready_rel", 64'(bus_b.ready), 64'd0);
    @(posedge clk); #1;
    check("b_ready_edge1", 64'(bus_b.ready), 64'd1);
    clear_b(); wr_b(0, 7, 64'h1); wr_b(1, 400, 64'hF); wr_b(2, 400, 64'hF);
    @(posedge clk); #1;
    check("b_oor_collision", 64'(bus_b.collision), 64'd0);
    clear_b(); rd_b(0, 7);
    @(posedge clk); #1;
    check("b_rd7", bus_b.rddata[0 +: DW], 64'h1);
    clear_b(); rd_b(0, 400);
    @(posedge clk); #1;
    check("b_rd400", bus_b.rddata[0 +: DW], 64'd0);
    check("b_rdv400", 64'(bus_b.rdvalid), 64'h1);
    clear_b(); wr_b(0, 7, 64'h2); rd_b(1, 7);
    @(posedge clk); #1;
    check("b_rdw_new", bus_b.rddata[1*DW +: DW], 64'h2);
    clear_b(); wr_b(0, 20, 64'hA); wr_b(2, 20, 64'hB);
    @(posedge clk); #1;
    check("b_collision", 64'(bus_b.collision), 64'h4);
    clear_b(); rd_b(3, 20);
    @(posedge clk); #1;
    check("b_rd20", bus_b.rddata[3*DW +: DW], 64'hA);
    check("b_collision_pulse", 64'(bus_b.collision), 64'd0);
    clear_b();
    @(posedge clk); #1;
    check("b_rdv_idle", 64'(bus_b.rdvalid), 64'd0);
    check("b_hold", bus_b.rddata[3*DW +: DW], 64'hA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/meduram_nwmr.md
Name: meduram_nwmr

Overview:
Parametrised multi-port RAM with NB_WR write ports and NB_RD read ports. It generalises the fixed 2-write/2-read top.
- Storage: one bank per write port, each bank replicated per read port.
- A live-value table (LVT) records which bank holds the latest value per address.
- Adds: post-reset clear sequence with a ready flag, selectable read-during-write mode, registered write-collision reporting.

Parameters:
NB_WR, 4, number of write ports (1..8)
NB_RD, 4, number of read ports (1..8)
ADDR_WIDTH, 9, address width per port
RAM_DEPTH, 512, words stored (<= 2**ADDR_WIDTH)
DATA_WIDTH, 64, word width
RDW_MODE, 0, read-during-write at same address: 0 = old data, 1 = new data
INIT_ON_RESET, 1, 1 = clear all words to zero after reset; 0 = skip clear

Ports:
aclk  in  1  clock, rising edge
arstn  in  1  asynchronous active-low reset
ready  out  1  high when ports are accepted
wren  in  NB_WR  per-port write enable
wraddr  in  NB_WR*ADDR_WIDTH  packed write addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wrdata  in  NB_WR*DATA_WIDTH  packed write data
rden  in  NB_RD  per-port read enable
rdaddr  in  NB_RD*ADDR_WIDTH  packed read addresses
rddata  out  NB_RD*DATA_WIDTH  packed read data
rdvalid  out  NB_RD  per-port one-cycle pulse, rddata valid
collision  out  NB_WR  per-port pulse, write lost arbitration

Behaviour:
- Reset (arstn low, asynchronous):
  - Outputs: ready=0, rddata=0, rdvalid=0, collision=0.
  - FSM goes to INIT (INIT_ON_RESET=1) or RUN (INIT_ON_RESET=0). Clear counter = 0.
- FSM states:
  - INIT: each cycle writes zero to every bank at address cnt and sets LVT[cnt]=0. cnt increments by 1.
  - INIT -> RUN: after cnt reaches RAM_DEPTH-1, so INIT lasts exactly RAM_DEPTH cycles after reset release.
  - RUN: ready=1, registered, first high in the cycle after the last clear. With INIT_ON_RESET=0, ready=1 on the first edge after reset release.
  - Reset asserted mid-INIT restarts the sweep from 0.
  - While ready=0: wren and rden are ignored, rdvalid stays 0, collision stays 0.
- Write path:
  - Port i with wren[i]=1 writes bank i at wraddr_i and sets LVT[wraddr_i]=i on the same edge.
  - Data is visible to reads issued the following cycle.
- Write collision: several ports write the same address in one cycle.
  - The lowest-index port wins; the other ports' writes are dropped (bank and LVT untouched).
  - collision[j]=1 for each losing port j, one cycle after the write, pulse width 1.
- Read path:
  - Latency 1: rden[k] sampled at edge N gives rddata_k and rdvalid[k]=1 after edge N+1.
  - Read value = bank[LVT[addr]][addr].
  - With rden[k]=0, rdvalid[k]=0 and rddata_k holds its last value.
- Read-during-write, same address, same edge:
  - RDW_MODE=0 returns the previous stored value.
  - RDW_MODE=1 returns the winning write's data (bypass mux).
- Out-of-range addresses (>= RAM_DEPTH):
  - Such a write is dropped and never counts in collision arbitration.
  - Such a read returns 0 with rdvalid=1.
- Ports are independent. All NB_RD reads are served every cycle with no stall and no backpressure.

Test Plan:
1. Defaults; release arstn -> ready=0 for exactly 512 cycles, then 1. Read addr 0..511 on all ports -> all 0, rdvalid=1 one cycle after each rden.
2. Port0 writes addr 5 = 0xAAAA, next cycle port3 writes addr 5 = 0x5555. Then all 4 read ports read 5 -> 0x5555 on each, one-cycle latency.
3. Ports 1, 2, 3 write addr 100 in the same cycle (0x11, 0x22, 0x33) -> collision=4'b1100 pulsed one cycle later. Read 100 -> 0x11.
4. RDW_MODE=0, addr 7 holds 0x1; port0 writes 7=0x2 while read port1 reads 7 -> 0x1. Repeat with RDW_MODE=1 -> 0x2.
5. Assert arstn at INIT cycle 200, release -> sweep restarts; ready rises 512 cycles after the second release. Writes and reads issued during INIT are ignored (rdvalid=0, memory still 0).
6. RAM_DEPTH=300, ADDR_WIDTH=9: write addr 400=0xF -> dropped, no collision. Read addr 400 -> 0, rdvalid=1. INIT_ON_RESET=0 -> ready=1 one edge after release.
